// File: rtl/bz_melody_seq.sv
// bz_melody_seq: plays a fixed 8-entry note table on the buzzer pin.
// Square-wave tone divider, tick-based duration timer, START/STOP handshake,
// one-cycle DONE pulse on normal completion and active-low status LEDs.
// Optional build macro BZ_GAP_EN: inserts GAP_TICKS silent ticks between notes.
module bz_melody_seq #(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned GAP_TICKS = 20
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STOP,
    output logic       BUSY,
    output logic       DONE,
    output logic [2:0] NOTE_IDX,
    output logic       BZ,
    output logic [2:0] RGB_LED
);

    // Clock cycles per duration tick
    localparam int unsigned TPT     = CLK_HZ / TICK_HZ;
    // Tone half-period reload values (counter runs 0..HP)
    localparam int unsigned HP_C5   = CLK_HZ / (2 * 523) - 1;
    localparam int unsigned HP_D5   = CLK_HZ / (2 * 587) - 1;
    localparam int unsigned HP_E5   = CLK_HZ / (2 * 659) - 1;
    localparam int unsigned TONE_W  = (HP_C5 > 0) ? $clog2(HP_C5 + 1) : 1;
    localparam int unsigned TICK_W  = $clog2(TPT + 1);
    localparam int unsigned DUR_MAX = (GAP_TICKS > 500) ? GAP_TICKS : 500;
    localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
`ifdef BZ_GAP_EN
        S_GAP,
`endif
        S_FIN
    } t_state;

    t_state              r_state;
    logic                r_busy;
    logic                r_done;
    logic [2:0]          r_idx;
    logic                r_bz;
    logic [2:0]          r_rgb;
    logic [TONE_W-1:0]   r_hp;
    logic [TONE_W-1:0]   r_tone;
    logic [TICK_W-1:0]   r_tick;
    logic [DUR_W-1:0]    r_dcnt;
    logic [DUR_W-1:0]    r_dlen;
    logic                r_rest;

    logic [TONE_W-1:0]   w_hp;
    logic [DUR_W-1:0]    w_dur;
    logic                w_rest;
    logic                w_tick_wrap;
    logic                w_note_end;
`ifdef BZ_GAP_EN
    logic [DUR_W-1:0]    w_next_dur;
    logic                w_gap_end;
`endif

    // Note table: half-period per entry (0 for rests and the end marker)
    function automatic logic [TONE_W-1:0] f_hp(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd6: f_hp = TONE_W'(HP_C5);
            3'd1, 3'd5: f_hp = TONE_W'(HP_D5);
            3'd2, 3'd4: f_hp = TONE_W'(HP_E5);
            default:    f_hp = '0;
        endcase
    endfunction

    // Note table: duration in ticks; 0 marks the end of the tune
    function automatic logic [DUR_W-1:0] f_dur(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f_dur = DUR_W'(250);
            3'd3:                         f_dur = DUR_W'(125);
            3'd6:                         f_dur = DUR_W'(500);
            default:                      f_dur = '0;
        endcase
    endfunction

    assign w_hp        = f_hp(r_idx);
    assign w_dur       = f_dur(r_idx);
    assign w_rest      = (r_idx == 3'd3);
    assign w_tick_wrap = (r_tick == TICK_W'(TPT - 1));
    assign w_note_end  = w_tick_wrap && (r_dcnt == r_dlen - 1'b1);
`ifdef BZ_GAP_EN
    // Gap only between two real notes: skipped before the end marker
    assign w_next_dur  = f_dur(r_idx + 3'd1);
    assign w_gap_end   = w_tick_wrap && (r_dcnt == DUR_W'(GAP_TICKS - 1));
`endif

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign NOTE_IDX = r_idx;
    assign BZ       = r_bz;
    assign RGB_LED  = r_rgb;

    // Sequencer FSM with tone, tick and duration counters and registered outputs
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_bz    <= 1'b0;
            r_rgb   <= 3'b111;
            r_hp    <= '0;
            r_tone  <= '0;
            r_tick  <= '0;
            r_dcnt  <= '0;
            r_dlen  <= '0;
            r_rest  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (STOP && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_idx   <= '0;
                r_bz    <= 1'b0;
                r_rgb   <= 3'b111;
                r_tone  <= '0;
                r_tick  <= '0;
                r_dcnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (START && !STOP) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                            r_idx   <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (w_dur == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_hp    <= w_hp;
                            r_dlen  <= w_dur;
                            r_rest  <= w_rest;
                            r_tone  <= '0;
                            r_tick  <= '0;
                            r_dcnt  <= '0;
                            r_bz    <= 1'b0;
                            r_rgb   <= w_rest ? 3'b101 : 3'b110;
                            r_state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (r_tone == r_hp) begin
                            r_tone <= '0;
                            if (!r_rest) begin
                                r_bz <= ~r_bz;
                            end
                        end else begin
                            r_tone <= r_tone + 1'b1;
                        end
                        if (w_tick_wrap) begin
                            r_tick <= '0;
                            r_dcnt <= r_dcnt + 1'b1;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                        // End-of-note overrides the counter updates above
                        if (w_note_end) begin
                            r_bz   <= 1'b0;
                            r_idx  <= r_idx + 3'd1;
                            r_tick <= '0;
                            r_dcnt <= '0;
`ifdef BZ_GAP_EN
                            if ((w_next_dur != '0) && (GAP_TICKS != 0)) begin
                                r_state <= S_GAP;
                                r_rgb   <= 3'b101;
                            end else begin
                                r_state <= S_LOAD;
                                r_rgb   <= 3'b111;
                            end
`else
                            r_state <= S_LOAD;
                            r_rgb   <= 3'b111;
`endif
                        end
                    end
`ifdef BZ_GAP_EN
                    S_GAP: begin
                        if (w_tick_wrap) begin
                            r_tick <= '0;
                            r_dcnt <= r_dcnt + 1'b1;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                        if (w_gap_end) begin
                            r_tick  <= '0;
                            r_dcnt  <= '0;
                            r_rgb   <= 3'b111;
                            r_state <= S_LOAD;
                        end
                    end
`endif
                    S_FIN: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_bz    <= 1'b0;
                        r_idx   <= r_idx + 3'd1;
                        r_rgb   <= 3'b111;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bz_melody_seq.sv
// Directed self-checking bench for bz_melody_seq (default build, no gap).
// Clock scaled to CLK_HZ=120000, TICK_HZ=10000: 12 cycles/tick,
// HP(523 Hz)=113 so the BZ period on entry 0 is 228 cycles, entry 0 = 3000 cycles.
module tb_bz_melody_seq;

    localparam int TPT        = 12;
    localparam int HP0        = 113;
    localparam int PER0       = 2 * (HP0 + 1);
    localparam int LEN0       = 250 * TPT;
    localparam int REST_LEN   = 125 * TPT;
    localparam int PITCH_LEN  = (1875 - 125) * TPT;
    localparam int DONE_CYC   = 7 + 1875 * TPT + 2;

    logic       CLK_IN = 1'b0;
    logic       RST_N  = 1'b0;
    logic       START  = 1'b0;
    logic       STOP   = 1'b0;
    logic       BUSY;
    logic       DONE;
    logic [2:0] NOTE_IDX;
    logic       BZ;
    logic [2:0] RGB_LED;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK_IN = ~CLK_IN;

    bz_melody_seq #(
        .CLK_HZ   (120000),
        .TICK_HZ  (10000),
        .GAP_TICKS(20)
    ) dut (
        .CLK_IN  (CLK_IN),
        .RST_N   (RST_N),
        .START   (START),
        .STOP    (STOP),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .NOTE_IDX(NOTE_IDX),
        .BZ      (BZ),
        .RGB_LED (RGB_LED)
    );

    task automatic cyc();
        @(negedge CLK_IN);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b0;
        STOP  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vec_cnt++;
            if ({BZ, BUSY, DONE, NOTE_IDX, RGB_LED} !== {1'b0, 1'b0, 1'b0, 3'd0, 3'b111}) begin
                err_cnt++;
                $display("FAIL reset_state[%0d]: got bz=%b busy=%b done=%b idx=%0d rgb=%b, expected 0 0 0 0 111",
                         i, BZ, BUSY, DONE, NOTE_IDX, RGB_LED);
            end
        end
        RST_N = 1'b1;
        cyc();
    endtask

    task automatic test_first_note();
        int len;
        int first_rise;
        int second_rise;
        logic prev_bz;
        START = 1'b1;
        cyc();
        START = 1'b0;
        vec_cnt++;
        if (BUSY !== 1'b1 || NOTE_IDX !== 3'd0) begin
            err_cnt++;
            $display("FAIL busy_rise: got busy=%b idx=%0d, expected busy=1 idx=0", BUSY, NOTE_IDX);
        end
        cyc();
        len = 0; first_rise = -1; second_rise = -1; prev_bz = 1'b0;
        while (RGB_LED === 3'b110 && len < 5000) begin
            if (BZ === 1'b1 && prev_bz === 1'b0) begin
                if (first_rise < 0) first_rise = len;
                else if (second_rise < 0) second_rise = len;
            end
            prev_bz = BZ;
            len++;
            cyc();
        end
        vec_cnt++;
        if (first_rise !== HP0 + 1) begin
            err_cnt++;
            $display("FAIL first_bz_rise: got %0d expected %0d", first_rise, HP0 + 1);
        end
        vec_cnt++;
        if (second_rise - first_rise !== PER0) begin
            err_cnt++;
            $display("FAIL bz_period: got %0d expected %0d", second_rise - first_rise, PER0);
        end
        vec_cnt++;
        if (len !== LEN0) begin
            err_cnt++;
            $display("FAIL entry0_len: got %0d expected %0d", len, LEN0);
        end
        vec_cnt++;
        if (NOTE_IDX !== 3'd1 || RGB_LED !== 3'b111 || BZ !== 1'b0) begin
            err_cnt++;
            $display("FAIL after_entry0: got idx=%0d rgb=%b bz=%b, expected idx=1 rgb=111 bz=0",
                     NOTE_IDX, RGB_LED, BZ);
        end
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        cyc();
    endtask

    task automatic test_full_tune();
        int rest_len = 0;
        int pitch_len = 0;
        int bz_bad = 0;
        int done_cnt = 0;
        int done_at = -1;
        int first7 = -1;
        logic busy_at_done = 1'bx;
        logic bz_at_done = 1'bx;
        logic busy_after = 1'bx;
        logic [2:0] idx_after = 3'bx;
        // START is held for the whole tune: ignored while busy, restarts after FIN
        START = 1'b1;
        cyc();
        for (int c = 0; c < 30000; c++) begin
            if (RGB_LED === 3'b101) rest_len++;
            if (RGB_LED === 3'b110) pitch_len++;
            if (RGB_LED !== 3'b110 && BZ !== 1'b0) bz_bad++;
            if (NOTE_IDX === 3'd7 && first7 < 0) first7 = c;
            if (DONE === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    busy_at_done = BUSY;
                    bz_at_done = BZ;
                end
            end
            if (done_at >= 0 && c == done_at + 1) begin
                busy_after = BUSY;
                idx_after = NOTE_IDX;
                break;
            end
            cyc();
        end
        START = 1'b0;
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        cyc();
        vec_cnt++;
        if (rest_len !== REST_LEN) begin
            err_cnt++;
            $display("FAIL rest_len: got %0d expected %0d", rest_len, REST_LEN);
        end
        vec_cnt++;
        if (pitch_len !== PITCH_LEN) begin
            err_cnt++;
            $display("FAIL pitched_len: got %0d expected %0d", pitch_len, PITCH_LEN);
        end
        vec_cnt++;
        if (bz_bad !== 0) begin
            err_cnt++;
            $display("FAIL bz_silent: got %0d cycles of bz=1 outside pitched play, expected 0", bz_bad);
        end
        vec_cnt++;
        if (done_at !== DONE_CYC) begin
            err_cnt++;
            $display("FAIL done_cycle: got %0d expected %0d", done_at, DONE_CYC);
        end
        vec_cnt++;
        if (first7 + 2 !== done_at) begin
            err_cnt++;
            $display("FAIL done_after_load7: got load7=%0d done=%0d, expected done=load7+2", first7, done_at);
        end
        vec_cnt++;
        if (done_cnt !== 1) begin
            err_cnt++;
            $display("FAIL done_pulses: got %0d expected 1", done_cnt);
        end
        vec_cnt++;
        if (busy_at_done !== 1'b0 || bz_at_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_at_done: got busy=%b bz=%b expected 0 0", busy_at_done, bz_at_done);
        end
        vec_cnt++;
        if (busy_after !== 1'b1 || idx_after !== 3'd0) begin
            err_cnt++;
            $display("FAIL held_start_restart: got busy=%b idx=%0d expected busy=1 idx=0", busy_after, idx_after);
        end
    endtask

    task automatic test_stop();
        int n = 0;
        int done_seen = 0;
        int busy_seen = 0;
        START = 1'b1;
        cyc();
        START = 1'b0;
        while (!(NOTE_IDX === 3'd2 && RGB_LED === 3'b110) && n < 8000) begin
            cyc();
            n++;
        end
        repeat (500) cyc();
        vec_cnt++;
        if (BUSY !== 1'b1 || NOTE_IDX !== 3'd2) begin
            err_cnt++;
            $display("FAIL stop_setup: got busy=%b idx=%0d expected busy=1 idx=2", BUSY, NOTE_IDX);
        end
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;
        vec_cnt++;
        if ({BUSY, BZ, DONE, NOTE_IDX, RGB_LED} !== {1'b0, 1'b0, 1'b0, 3'd0, 3'b111}) begin
            err_cnt++;
            $display("FAIL stop_idle: got busy=%b bz=%b done=%b idx=%0d rgb=%b expected 0 0 0 0 111",
                     BUSY, BZ, DONE, NOTE_IDX, RGB_LED);
        end
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (DONE !== 1'b0) done_seen++;
            if (BUSY !== 1'b0) busy_seen++;
        end
        vec_cnt++;
        if (done_seen !== 0 || busy_seen !== 0) begin
            err_cnt++;
            $display("FAIL stop_no_done: got done=%0d busy=%0d cycles, expected 0 0", done_seen, busy_seen);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int zero_seen = 0;
        START = 1'b1;
        cyc();
        START = 1'b0;
        while (NOTE_IDX !== 3'd1 && n < 4000) begin
            cyc();
            n++;
        end
        repeat (100) cyc();
        START = 1'b1;
        cyc();
        START = 1'b0;
        vec_cnt++;
        if (BUSY !== 1'b1 || NOTE_IDX !== 3'd1) begin
            err_cnt++;
            $display("FAIL start_while_busy: got busy=%b idx=%0d expected busy=1 idx=1", BUSY, NOTE_IDX);
        end
        n = 0;
        while (NOTE_IDX !== 3'd2 && n < 4000) begin
            if (NOTE_IDX === 3'd0) zero_seen++;
            cyc();
            n++;
        end
        vec_cnt++;
        if (NOTE_IDX !== 3'd2 || zero_seen !== 0) begin
            err_cnt++;
            $display("FAIL no_restart: got idx=%0d zero_cycles=%0d expected idx=2 zero_cycles=0",
                     NOTE_IDX, zero_seen);
        end
        START = 1'b1;
        STOP  = 1'b1;
        cyc();
        vec_cnt++;
        if ({BUSY, DONE, NOTE_IDX, RGB_LED} !== {1'b0, 1'b0, 3'd0, 3'b111}) begin
            err_cnt++;
            $display("FAIL start_stop_same: got busy=%b done=%b idx=%0d rgb=%b expected 0 0 0 111",
                     BUSY, DONE, NOTE_IDX, RGB_LED);
        end
        cyc();
        vec_cnt++;
        if (BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL stop_wins_idle: got busy=%b expected 0", BUSY);
        end
        START = 1'b0;
        STOP  = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_full_tune();
        test_stop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
